// File: rtl/sl3_pkg.sv
// Shared types and sync-byte layout for the SerialLite III TX burst arbiter.
package sl3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } sl3_arb_state_t;

    localparam int SL3_SYNC_CONT_BIT = 7;
    localparam int SL3_SYNC_SRC_LSB  = 0;
    localparam int SL3_SYNC_SRC_W    = 3;

    // Sync byte: continuation flag plus source index, all other bits zero.
    function automatic logic [7:0] sl3_sync_word(input logic cont,
                                                 input logic [SL3_SYNC_SRC_W-1:0] src);
        logic [7:0] w;
        w = 8'h00;
        w[SL3_SYNC_CONT_BIT] = cont;
        w[SL3_SYNC_SRC_LSB +: SL3_SYNC_SRC_W] = src;
        return w;
    endfunction

endpackage

// File: rtl/sl3_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module sl3_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin : pick
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (req[idx]) begin
                gnt_idx = IW'(idx);
                any     = 1'b1;
            end else begin
                any     = any;
            end
        end
    end

endmodule

// File: rtl/sl3_tx_burst_arbiter.sv
// Round-robin burst arbiter sharing one SerialLite III TX stream between NUM_REQ
// requesters; splits long bursts, tags sources on sync_tx and flushes on link loss.
module sl3_tx_burst_arbiter
    import sl3_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 64
) (
    input  logic                      user_clock_tx,
    input  logic                      user_clock_reset_tx,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_eob,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         data_tx,
    output logic                      valid_tx,
    output logic                      start_of_burst_tx,
    output logic                      end_of_burst_tx,
    output logic [7:0]                sync_tx,
    input  logic                      ready_tx,
    input  logic                      link_up_tx,
    output logic [15:0]               drop_count
);

    localparam int         IW        = $clog2(NUM_REQ);
    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST);

    sl3_arb_state_t      state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  cont_q, cont_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                sob_q, sob_d;
    logic                eob_q, eob_d;
    logic [7:0]          sync_q, sync_d;

    logic [IW-1:0]       pick_idx_s;
    logic                pick_any_s;
    logic                load_ok_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic                beat_acc_s;
    logic                beat_eob_s;
    logic                beat_last_s;
    logic [8:0]          beat_num_s;
    logic [DATA_W-1:0]   beat_data_s;

    sl3_rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    assign load_ok_s   = !valid_q || ready_tx;
    assign beat_data_s = req_data[int'(gnt_q)*DATA_W +: DATA_W];
    assign beat_acc_s  = req_valid[gnt_q] && ready_s[gnt_q];
    assign beat_eob_s  = req_eob[gnt_q];
    assign beat_num_s  = {1'b0, beat_cnt_q} + 9'd1;
    assign beat_last_s = beat_eob_s || (beat_num_s == MAX_BEATS);

    // Only the granted requester is ever ready; in DRAIN it is drained unconditionally.
    always_comb begin
        ready_s = '0;
        case (state_q)
            BURST:   ready_s[gnt_q] = load_ok_s;
            DRAIN:   ready_s[gnt_q] = 1'b1;
            default: ready_s = '0;
        endcase
    end

    // Next-state, arbitration and output-register load/clear decisions.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        cont_d     = cont_q;
        beat_cnt_d = beat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sob_d      = sob_q;
        eob_d      = eob_q;
        sync_d     = sync_q;
        case (state_q)
            IDLE: begin
                // A beat stuck behind backpressure is discarded once the link is gone.
                if (load_ok_s || !link_up_tx) begin
                    {valid_d, sob_d, eob_d, sync_d, data_d} = '0;
                end else begin
                    valid_d = valid_q;
                end
                if (link_up_tx && pick_any_s) begin
                    state_d    = BURST;
                    gnt_d      = pick_idx_s;
                    rr_ptr_d   = (pick_idx_s == IW'(NUM_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
                    beat_cnt_d = 8'd0;
                end else begin
                    state_d    = IDLE;
                end
            end
            BURST: begin
                if (!link_up_tx) begin
                    {valid_d, sob_d, eob_d, sync_d, data_d} = '0;
                    drop_cnt_d     = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                    cont_d[gnt_q]  = 1'b0;
                    state_d        = (beat_acc_s && beat_eob_s) ? IDLE : DRAIN;
                end else if (beat_acc_s) begin
                    data_d     = beat_data_s;
                    valid_d    = 1'b1;
                    sob_d      = (beat_cnt_q == 8'd0);
                    eob_d      = beat_last_s;
                    sync_d     = sl3_sync_word(cont_q[gnt_q], SL3_SYNC_SRC_W'(gnt_q));
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_eob_s) begin
                        cont_d[gnt_q] = 1'b0;
                        state_d       = IDLE;
                    end else if (beat_num_s == MAX_BEATS) begin
                        cont_d[gnt_q] = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d       = BURST;
                    end
                end else if (load_ok_s) begin
                    {valid_d, sob_d, eob_d, sync_d, data_d} = '0;
                end else begin
                    state_d = BURST;
                end
            end
            DRAIN: begin
                {valid_d, sob_d, eob_d, sync_d, data_d} = '0;
                if (beat_acc_s && beat_eob_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                {valid_d, sob_d, eob_d, sync_d, data_d} = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge user_clock_tx) begin
        if (user_clock_reset_tx) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            cont_q     <= '0;
            beat_cnt_q <= 8'd0;
            drop_cnt_q <= 16'd0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sob_q      <= 1'b0;
            eob_q      <= 1'b0;
            sync_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            cont_q     <= cont_d;
            beat_cnt_q <= beat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sob_q      <= sob_d;
            eob_q      <= eob_d;
            sync_q     <= sync_d;
        end
    end

    assign req_ready         = ready_s;
    assign data_tx           = data_q;
    assign valid_tx          = valid_q;
    assign start_of_burst_tx = sob_q;
    assign end_of_burst_tx   = eob_q;
    assign sync_tx           = sync_q;
    assign drop_count        = drop_cnt_q;

endmodule

// File: doc/sl3_tx_burst_arbiter.md
# sl3_tx_burst_arbiter

- Shares the single 256-bit SerialLite III 4-lane TX stream between `NUM_REQ` requester streams.
- Arbitrates round-robin at burst granularity and frames each grant as one SerialLite burst.
- Tags each burst with its source index on `sync_tx`, splits bursts longer than `MAX_BURST` beats, and flushes in-flight bursts when the link drops.
- Sits in the `user_clock_tx` domain, directly in front of the TX side of the SerialLite III wrapper.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; range 2..8.
- `DATA_W`, default 256: beat width; must match `data_tx`.
- `MAX_BURST`, default 64: maximum beats per emitted burst; range 2..256.

Ports:
- `user_clock_tx` in 1: clock.
- `user_clock_reset_tx` in 1: reset, synchronous, active-high.
- `req_data` in `NUM_REQ*DATA_W`: requester beats, packed; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_valid` in `NUM_REQ`: per-requester beat valid.
- `req_eob` in `NUM_REQ`: last beat of the requester's burst; qualified by `req_valid`.
- `req_ready` out `NUM_REQ`: beat accepted when valid && ready; at most one bit set.
- `data_tx` out `DATA_W`: to the wrapper.
- `valid_tx` out 1: to the wrapper.
- `start_of_burst_tx` out 1: to the wrapper.
- `end_of_burst_tx` out 1: to the wrapper.
- `sync_tx` out 8: bits [2:0] carry the source index; bit 7 is the continuation flag; other bits are 0.
- `ready_tx` in 1: from the wrapper.
- `link_up_tx` in 1: from the wrapper.
- `drop_count` out 16: number of bursts flushed because the link went down; saturates at 0xFFFF.

## Operation

States:
- **IDLE**: arbitrates.
- **BURST**: streams the granted requester.
- **DRAIN**: discards the granted requester's beats until its eob.

Arbitration:
- In IDLE with `link_up_tx`=1 and any `req_valid`, grant the first valid index at or after `rr_ptr`, searching with wrap-around.
- On a grant: register `gnt`, set `rr_ptr` to `gnt+1` mod `NUM_REQ`, and go to BURST.

Output register:
- Holds one beat.
- It may load when `valid_tx`=0 or `ready_tx`=1.
- While `valid_tx`=1 && `ready_tx`=0, all outputs hold stable.

In BURST:
- `req_ready[gnt]` = (`valid_tx`=0 or `ready_tx`=1); every other `req_ready` bit is 0.
- Each accepted beat is loaded into the output register together with:
  - `start_of_burst_tx` = 1 on the first beat of the grant;
  - `end_of_burst_tx` = 1 on the last beat;
  - `sync_tx` = {`cont[gnt]`, 4'b0, `gnt`[2:0]}.
- `beat_cnt` (8-bit) counts the beats accepted in this grant.
- If the requester's eob is accepted, clear `cont[gnt]` and go to IDLE.
- If beat number `MAX_BURST` is accepted without eob:
  - force `end_of_burst_tx` on that beat;
  - set `cont[gnt]` = 1 and go to IDLE;
  - the requester re-competes, and its next burst carries `sync_tx[7]`=1.
- If `MAX_BURST` is reached on an eob beat, eob takes priority and `cont` is cleared.

Link loss:
- `link_up_tx`=0 in BURST:
  - drop the output register (`valid_tx`←0);
  - increment `drop_count` (saturating);
  - clear `cont[gnt]`;
  - go to DRAIN.
- If the link drops on the same cycle that eob is accepted, the burst still counts as dropped.
- In DRAIN, `req_ready[gnt]`=1 and accepted beats are discarded; go to IDLE when an eob is accepted.
- `link_up_tx`=0 in IDLE blocks new grants. A pending `valid_tx` with `ready_tx`=0 is cleared without counting a drop.

## Timing

- Reset: all outputs are 0; `rr_ptr`=0, `cont`=0, `beat_cnt`=0; state is IDLE.
- Grant latency: `req_valid` is sampled in IDLE at cycle T; `req_ready` rises at T+1.
- Data latency: a beat accepted at cycle T appears on `data_tx` at T+1.
- Bubble: one IDLE cycle between consecutive bursts. With all requesters saturated and `MAX_BURST`=M, throughput is M/(M+1).
- No combinational path from `req_*` to the `*_tx` outputs.
- `req_ready` depends combinationally on `ready_tx` and registered state only.
- Reset asserted mid-burst: next cycle all outputs are 0, and the partial burst is abandoned with no drop count.

## Structure

Shared package `sl3_pkg` holds:
- the state enum `sl3_arb_state_t` (IDLE, BURST, DRAIN);
- `SL3_SYNC_CONT_BIT` = 7;
- `SL3_SYNC_SRC_LSB` = 0;
- `SL3_SYNC_SRC_W` = 3.

One sub-module: `sl3_rr_pick`, a combinational round-robin priority picker with inputs `req`, `ptr` and outputs `gnt_idx`, `any`.

## Test plan

- **Single burst:** requester 2 sends 3 beats (eob on beat 3) with `ready_tx`=1 → 3 `data_tx` beats; SOB on beat 1, EOB on beat 3; `sync_tx`=0x02; `req_ready[2]` high exactly 3 cycles.
- **Fairness:** all 4 requesters send continuous 1-beat bursts → grant order 0,1,2,3,0,...; one idle cycle between bursts.
- **Split:** `MAX_BURST`=4, requester 1 sends 10 beats → bursts of 4/4/2; `sync_tx` = 0x01, 0x81, 0x81; EOB on beats 4, 8, 10.
- **Backpressure:** `ready_tx` toggles 1,0,0,1 mid-burst → outputs stable while low; no beat lost or duplicated; burst order preserved.
- **Link drop:** `link_up_tx` falls at beat 2 of a 5-beat burst → `valid_tx` is 0 the next cycle; `drop_count`=1; remaining beats are consumed through eob; no grant until the link returns.
- **Reset mid-burst:** reset asserted at beat 3 → all outputs 0 on the next cycle; after release the first grant goes to the lowest valid index.
